// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : alu_pkg
//  Description : Shared encodings for the ALU issue stage and its helpers:
//                ALU op codes, operand-A/B source selects and the hard-wired
//                zero register index.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    SLL  = 4'd5,
    SRL  = 4'd6,
    SRA  = 4'd7,
    SLT  = 4'd8,
    SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    A_RS1     = 2'd0,
    A_PC      = 2'd1,
    A_ZERO    = 2'd2,
    A_RS1_ALT = 2'd3   // reserved encoding, behaves as rs1
  } a_sel_e;

  typedef enum logic {
    B_RS2 = 1'b0,
    B_IMM = 1'b1
  } b_sel_e;

  // Register x0: never a forwarding target.
  localparam int unsigned ZERO_IDX = 0;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_mux
//  Description : Per-operand RAW bypass. Picks the newest value of register
//                'idx' from EX/MEM, then MEM/WB, else the held value.
//  Ports       : idx/held_val          - operand index and held value
//                exm_* / mwb_*         - write-back sources (EX/MEM newer)
//                fwd_val               - resolved operand value
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REGIDX = 5
) (
  input  logic [REGIDX-1:0] idx,
  input  logic [XLEN-1:0]   held_val,
  input  logic              exm_reg_write,
  input  logic [REGIDX-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_result,
  input  logic              mwb_reg_write,
  input  logic [REGIDX-1:0] mwb_rd,
  input  logic [XLEN-1:0]   mwb_result,
  output logic [XLEN-1:0]   fwd_val
);

  logic w_not_x0;
  logic w_exm_hit;
  logic w_mwb_hit;

  // x0 is architecturally zero; a producer "writing" it must not bypass.
  assign w_not_x0  = (idx != REGIDX'(ZERO_IDX));
  assign w_exm_hit = w_not_x0 && exm_reg_write && (exm_rd == idx);
  assign w_mwb_hit = w_not_x0 && mwb_reg_write && (mwb_rd == idx);

  // EX/MEM holds the younger producer, so it wins over MEM/WB.
  always_comb begin
    fwd_val = held_val;
    if (w_exm_hit) begin
      fwd_val = exm_result;
    end else if (w_mwb_hit) begin
      fwd_val = mwb_result;
    end
  end

endmodule : fwd_mux
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage
//  Description : ID/EX register ahead of the ALU. Holds one decoded
//                instruction, bypasses RAW hazards from EX/MEM and MEM/WB,
//                and presents A/B/op under a valid/ready handshake.
//  Ports       : in_*            - decode-side instruction + handshake
//                flush           - drop the held / offered instruction
//                exm_* / mwb_*   - write-back sources for forwarding
//                out_valid/ready - ALU-side handshake
//                alu_a/b/op      - ALU operands
//                out_rd, out_reg_write, out_store_data - carried downstream
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REGIDX = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1_val,
  input  logic [XLEN-1:0]   in_rs2_val,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [REGIDX-1:0] in_rs1_idx,
  input  logic [REGIDX-1:0] in_rs2_idx,
  input  logic [REGIDX-1:0] in_rd_idx,
  input  logic [1:0]        in_a_sel,
  input  logic              in_b_sel,
  input  logic [3:0]        in_alu_op,
  input  logic              in_reg_write,
  input  logic              flush,
  input  logic              exm_reg_write,
  input  logic [REGIDX-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_result,
  input  logic              mwb_reg_write,
  input  logic [REGIDX-1:0] mwb_rd,
  input  logic [XLEN-1:0]   mwb_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [3:0]        alu_op,
  output logic [REGIDX-1:0] out_rd,
  output logic              out_reg_write,
  output logic [XLEN-1:0]   out_store_data
);

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1_val;
  logic [XLEN-1:0]   r_rs2_val;
  logic [XLEN-1:0]   r_imm;
  logic [REGIDX-1:0] r_rs1_idx;
  logic [REGIDX-1:0] r_rs2_idx;
  logic [REGIDX-1:0] r_rd;
  a_sel_e            r_a_sel;
  b_sel_e            r_b_sel;
  alu_op_e           r_op;
  logic              r_reg_write;

  logic [XLEN-1:0]   w_rs1_fwd;
  logic [XLEN-1:0]   w_rs2_fwd;
  logic              w_accept;
  logic              w_hold;

  assign in_ready = !r_valid || out_ready;
  // Flush overrides an accept in the same cycle: the offered word is lost.
  assign w_accept = in_valid && in_ready && !flush;
  assign w_hold   = r_valid && !out_ready;

  fwd_mux #(.XLEN(XLEN), .REGIDX(REGIDX)) u_fwd_rs1 (
    .idx           (r_rs1_idx),
    .held_val      (r_rs1_val),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_result    (mwb_result),
    .fwd_val       (w_rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN), .REGIDX(REGIDX)) u_fwd_rs2 (
    .idx           (r_rs2_idx),
    .held_val      (r_rs2_val),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_result    (mwb_result),
    .fwd_val       (w_rs2_fwd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      r_valid <= 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= '0;
      r_rs1_val   <= '0;
      r_rs2_val   <= '0;
      r_imm       <= '0;
      r_rs1_idx   <= '0;
      r_rs2_idx   <= '0;
      r_rd        <= '0;
      r_a_sel     <= A_RS1;
      r_b_sel     <= B_RS2;
      r_op        <= ADD;
      r_reg_write <= 1'b0;
    end else if (w_accept) begin
      r_pc        <= in_pc;
      r_rs1_val   <= in_rs1_val;
      r_rs2_val   <= in_rs2_val;
      r_imm       <= in_imm;
      r_rs1_idx   <= in_rs1_idx;
      r_rs2_idx   <= in_rs2_idx;
      r_rd        <= in_rd_idx;
      r_a_sel     <= a_sel_e'(in_a_sel);
      r_b_sel     <= b_sel_e'(in_b_sel);
      r_op        <= alu_op_e'(in_alu_op);
      r_reg_write <= in_reg_write;
    end else if (w_hold) begin
      // Capture any bypass seen during a stall; the producer may retire
      // before the stall ends and the value would otherwise be lost.
      r_rs1_val <= w_rs1_fwd;
      r_rs2_val <= w_rs2_fwd;
    end
  end

  always_comb begin
    alu_a = w_rs1_fwd;
    case (r_a_sel)
      A_PC:    alu_a = r_pc;
      A_ZERO:  alu_a = '0;
      default: alu_a = w_rs1_fwd;
    endcase
  end

  assign alu_b          = (r_b_sel == B_IMM) ? r_imm : w_rs2_fwd;
  assign alu_op         = r_op;
  assign out_valid      = r_valid;
  assign out_rd         = r_rd;
  assign out_reg_write  = r_valid && r_reg_write;
  assign out_store_data = w_rs2_fwd;

endmodule : alu_issue_stage
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_stage
//  Description : Self-checking bench for alu_issue_stage. A behavioural
//                model tracks the held instruction; a negedge process
//                compares every cycle, directed tests add literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
  logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd_idx;
  logic [1:0]  in_a_sel;
  logic        in_b_sel;
  logic [3:0]  in_alu_op;
  logic        in_reg_write;
  logic        flush;
  logic        exm_reg_write, mwb_reg_write;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_result;
  logic        out_valid, out_ready;
  logic [31:0] alu_a, alu_b, out_store_data;
  logic [3:0]  alu_op;
  logic [4:0]  out_rd;
  logic        out_reg_write;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue_stage #(.XLEN(32), .REGIDX(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_imm(in_imm), .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
    .in_rd_idx(in_rd_idx), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
    .in_alu_op(in_alu_op), .in_reg_write(in_reg_write), .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_store_data(out_store_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  asel;
    logic        bsel;
    logic [3:0]  op;
    logic        rw;
  } instr_t;

  logic   m_valid;
  instr_t m;

  // Newest architectural value of a register as seen this cycle.
  function automatic logic [31:0] newest(input logic [4:0] idx, input logic [31:0] v);
    if (idx == 5'd0) return v;
    if (exm_reg_write && exm_rd == idx) return exm_result;
    if (mwb_reg_write && mwb_rd == idx) return mwb_result;
    return v;
  endfunction

  function automatic logic [31:0] exp_a();
    if (m.asel == 2'd1) return m.pc;
    if (m.asel == 2'd2) return 32'd0;
    return newest(m.rs1, m.rs1v);
  endfunction

  function automatic logic [31:0] exp_b();
    return m.bsel ? m.imm : newest(m.rs2, m.rs2v);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m       <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid <= 1'b1;
      m.pc <= in_pc;       m.rs1v <= in_rs1_val; m.rs2v <= in_rs2_val;
      m.imm <= in_imm;     m.rs1 <= in_rs1_idx;  m.rs2 <= in_rs2_idx;
      m.rd <= in_rd_idx;   m.asel <= in_a_sel;   m.bsel <= in_b_sel;
      m.op <= in_alu_op;   m.rw <= in_reg_write;
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end else if (m_valid) begin
      m.rs1v <= newest(m.rs1, m.rs1v);
      m.rs2v <= newest(m.rs2, m.rs2v);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
      if (m_valid) begin
        check("alu_a", alu_a, exp_a());
        check("alu_b", alu_b, exp_b());
        check("alu_op", {28'd0, alu_op}, {28'd0, m.op});
        check("out_rd", {27'd0, out_rd}, {27'd0, m.rd});
        check("out_reg_write", {31'd0, out_reg_write}, {31'd0, m.rw});
        check("store_data", out_store_data, newest(m.rs2, m.rs2v));
      end else begin
        check("out_reg_write_idle", {31'd0, out_reg_write}, 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic [1:0] asel, input logic bsel,
                       input logic [3:0] op);
    in_valid = 1'b1; in_pc = pc; in_rs1_val = v1; in_rs2_val = v2; in_imm = imm;
    in_rs1_idx = r1; in_rs2_idx = r2; in_rd_idx = rd; in_a_sel = asel;
    in_b_sel = bsel; in_alu_op = op; in_reg_write = 1'b1;
  endtask

  task automatic clear_wb();
    exm_reg_write = 1'b0; exm_rd = '0; exm_result = '0;
    mwb_reg_write = 1'b0; mwb_rd = '0; mwb_result = '0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_pc = '0; in_rs1_val = '0; in_rs2_val = '0; in_imm = '0;
    in_rs1_idx = '0; in_rs2_idx = '0; in_rd_idx = '0; in_a_sel = '0;
    in_b_sel = 1'b0; in_alu_op = '0; in_reg_write = 1'b0;
    clear_wb();

    // Reset state
    #12;
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst alu_a", alu_a, 32'd0);
    check("rst alu_b", alu_b, 32'd0);
    check("rst alu_op", {28'd0, alu_op}, 32'd0);
    check("rst out_reg_write", {31'd0, out_reg_write}, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst = 1'b0;

    // 1: simple ADD, latency 1
    out_ready = 1'b1;
    offer(32'h100, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 2'd0, 1'b0, 4'd0);
    tick();
    in_valid = 1'b0;
    check("t1 out_valid", {31'd0, out_valid}, 32'd1);
    check("t1 alu_a", alu_a, 32'd5);
    check("t1 alu_b", alu_b, 32'd7);
    check("t1 alu_op", {28'd0, alu_op}, 32'd0);
    tick();

    // 2: EX/MEM beats MEM/WB; x0 never forwarded
    out_ready = 1'b0;
    offer(32'h104, 32'h11, 32'h0, 32'h0, 5'd3, 5'd4, 5'd5, 2'd0, 1'b0, 4'd1);
    tick();
    in_valid = 1'b0;
    exm_reg_write = 1'b1; exm_rd = 5'd3; exm_result = 32'hAA;
    mwb_reg_write = 1'b1; mwb_rd = 5'd3; mwb_result = 32'hBB;
    #1 check("t2 exm priority", alu_a, 32'hAA);
    out_ready = 1'b1;
    tick();
    offer(32'h108, 32'h22, 32'h0, 32'h0, 5'd0, 5'd0, 5'd6, 2'd0, 1'b0, 4'd2);
    exm_rd = 5'd0; mwb_rd = 5'd0;
    tick();
    in_valid = 1'b0;
    check("t2 x0 held", alu_a, 32'h22);
    check("t2 x0 store", out_store_data, 32'h0);
    tick();
    clear_wb();

    // 3: stall 3 cycles, MEM/WB refresh of rs2 mid-stall
    out_ready = 1'b0;
    offer(32'h10C, 32'h1, 32'h55, 32'h0, 5'd7, 5'd6, 5'd8, 2'd0, 1'b0, 4'd3);
    tick();
    in_valid = 1'b0;
    check("t3 in_ready c1", {31'd0, in_ready}, 32'd0);
    tick();
    mwb_reg_write = 1'b1; mwb_rd = 5'd6; mwb_result = 32'h1234;
    check("t3 in_ready c2", {31'd0, in_ready}, 32'd0);
    tick();
    clear_wb();
    check("t3 in_ready c3", {31'd0, in_ready}, 32'd0);
    check("t3 alu_b stalled", alu_b, 32'h1234);
    out_ready = 1'b1;
    #1 check("t3 alu_b release", alu_b, 32'h1234);
    tick();

    // 4: flush dominates a simultaneous offer
    out_ready = 1'b0;
    offer(32'h110, 32'h9, 32'h9, 32'h0, 5'd1, 5'd2, 5'd9, 2'd0, 1'b0, 4'd4);
    tick();
    offer(32'h114, 32'h77, 32'h77, 32'h0, 5'd1, 5'd2, 5'd10, 2'd0, 1'b0, 4'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("t4 flushed", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    tick();
    check("t4 dropped", {31'd0, out_valid}, 32'd0);

    // 5: back-to-back, order preserved (a_sel=PC exposes the PC)
    for (int i = 0; i < 4; i++) begin
      offer(32'h200 + 32'(i * 4), 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'(i + 1), 2'd1, 1'b0, 4'(i + 1));
      tick();
      check("t5 valid", {31'd0, out_valid}, 32'd1);
      check("t5 order", alu_a, 32'h200 + 32'(i * 4));
    end
    // Mixed selects, including a_sel=2/3, imm, and an EX/MEM bypass on rs2
    offer(32'h300, 32'h40, 32'h50, 32'hFFFF_FFF0, 5'd1, 5'd2, 5'd3, 2'd2, 1'b1, 4'd6);
    tick();
    offer(32'h304, 32'h41, 32'h51, 32'h8, 5'd1, 5'd2, 5'd3, 2'd3, 1'b1, 4'd7);
    tick();
    offer(32'h308, 32'h42, 32'h52, 32'h0, 5'd1, 5'd2, 5'd3, 2'd0, 1'b0, 4'd9);
    exm_reg_write = 1'b1; exm_rd = 5'd2; exm_result = 32'hCAFE;
    tick();
    in_valid = 1'b0;
    check("t5 store fwd", out_store_data, 32'hCAFE);
    clear_wb();
    // Async reset mid-stream
    offer(32'h30C, 32'h43, 32'h53, 32'h0, 5'd1, 5'd2, 5'd3, 2'd0, 1'b0, 4'd8);
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t5 rst valid", {31'd0, out_valid}, 32'd0);
    check("t5 rst alu_op", {28'd0, alu_op}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_alu_issue_stage
`default_nettype wire
